mul_div_control: RTL and testbench

MUL_DIV_CONTROL -- requirements
Module: mul_div_control

---
 rtl/mul_div_pkg.sv | 22 ++
 rtl/mul_div_iter.sv | 72 +++++++
 rtl/mul_div_control.sv | 80 ++++++++
 tb/tb_mul_div_control.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: Funct codes, FSM encoding and Funct decode shared by the mul/div unit and ALU-side decode.
// DIV/DIVU decode as supported only when MULDIV_DIV_EN is defined.
package mul_div_pkg;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic is_muldiv(input logic [5:0] f);
`ifdef MULDIV_DIV_EN
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
`else
        return f inside {F_MULT, F_MULTU};
`endif
    endfunction
    function automatic logic is_supported(input logic [5:0] f);
        return is_muldiv(f) || f == F_MTHI || f == F_MTLO;
    endfunction
endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: radix-2 shift-add multiply / restoring divide on operand magnitudes with final sign fix.
// The divide datapath exists only when MULDIV_DIV_EN is defined.
module mul_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             is_unsigned,
`ifdef MULDIV_DIV_EN
    input  logic             is_div,
    output logic             b_zero,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int W = WIDTH;
    logic [2*W:0] p, p_nx;
    logic [W-1:0] m, mag_a, mag_b;
    logic [W:0] sum;
    logic [2*W-1:0] prod;
    logic neg_p, div_op;
    assign mag_a = (!is_unsigned && a[W-1]) ? -a : a;
    assign mag_b = (!is_unsigned && b[W-1]) ? -b : b;
`ifdef MULDIV_DIV_EN
    logic [W-1:0] a_q, q, r;
    logic [W:0] diff;
    logic div_q, neg_r, zero_q;
    assign div_op = is_div;
    assign b_zero = div_q && zero_q;
    always_ff @(posedge clk) begin
        if (load) begin
            a_q    <= a;
            div_q  <= is_div;
            neg_r  <= !is_unsigned && a[W-1];
            zero_q <= b == '0;
        end
    end
`else
    assign div_op = 1'b0;
`endif
    // p holds {carry/remainder, product-low/quotient}; m is the multiplicand or divisor magnitude
    always_ff @(posedge clk) begin
        if (load) begin
            neg_p <= !is_unsigned && (a[W-1] ^ b[W-1]);
            m     <= div_op ? mag_b : mag_a;
            p     <= {(W+1)'(0), div_op ? mag_a : mag_b};
        end else if (step)
            p <= p_nx;
    end
    always_comb begin
        sum    = p[2*W:W] + (p[0] ? {1'b0, m} : '0);
        p_nx   = {1'b0, sum, p[W-1:1]};
        prod   = neg_p ? -p_nx[2*W-1:0] : p_nx[2*W-1:0];
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
`ifdef MULDIV_DIV_EN
        diff   = p[2*W-1:W-1] - {1'b0, m};
        q      = '0;
        r      = '0;
        if (div_q) begin
            p_nx   = diff[W] ? {p[2*W-1:0], 1'b0} : {diff, p[W-2:0], 1'b1};
            q      = p_nx[W-1:0];
            r      = p_nx[2*W-1:W];
            res_lo = zero_q ? '1 : neg_p ? -q : q;
            res_hi = zero_q ? a_q : neg_r ? -r : r;
        end
`endif
    end
endmodule

// File: rtl/mul_div_control.sv
// mul_div_control: MIPS HI/LO unit -- FSM, iteration counter, HI/LO registers and status pulses.
// MULDIV_DIV_EN enables DIV/DIVU; otherwise they decode as illegal and div_zero is tied low.
module mul_div_control
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic req, accept, last, commit;
    assign req    = state == IDLE && start && !flush;
    assign accept = req && is_muldiv(Funct);
    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign commit = state == BUSY && !flush && last;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    always_comb begin
        state_nx = state == IDLE ? (accept ? BUSY : IDLE)
                 : state == BUSY ? (flush ? IDLE : last ? DONE : BUSY)
                 : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= accept ? '0 : cnt + 1'b1;
            illegal <= req && !is_supported(Funct);
            if (req && Funct == F_MTHI) hi <= A;
            if (req && Funct == F_MTLO) lo <= A;
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
`ifdef MULDIV_DIV_EN
    logic b_zero;
    always_ff @(posedge clk) begin
        if (!reset_n) div_zero <= 1'b0;
        else div_zero <= commit && b_zero;
    end
`else
    assign div_zero = 1'b0;
`endif
    mul_div_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .load        (accept),
        .step        (state == BUSY),
        .is_unsigned (Funct[0]),
`ifdef MULDIV_DIV_EN
        .is_div      (Funct[1]),
        .b_zero      (b_zero),
`endif
        .a           (A),
        .b           (B),
        .res_hi      (res_hi),
        .res_lo      (res_lo)
    );
endmodule

// File: tb/tb_mul_div_control.sv
// tb_mul_div_control: randomized checks of mul_div_control against an arithmetic HI/LO model.
// Divide scenarios follow the MULDIV_DIV_EN build option.
module tb_mul_div_control;
    import mul_div_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [5:0] Funct = '0;
    logic [31:0] A = '0, B = '0;
    logic busy, done, illegal, div_zero;
    logic [31:0] hi, lo;
    logic [63:0] hl_model = '0;
    int n_chk = 0, n_fail = 0;

    mul_div_control #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .Funct(Funct), .A(A), .B(B), .flush(flush),
        .busy(busy), .done(done), .illegal(illegal), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (f == F_MULT) return $signed(sa) * $signed(sb);
        if (f == F_MULTU) return ua * ub;
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (f == F_DIV) begin
            q = $signed(sa) / $signed(sb);
            r = $signed(sa) % $signed(sb);
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        while (busy && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        @(negedge clk);
        start = 1'b1; Funct = f; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(output int lat, output logic dz);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        dz = div_zero;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, done, illegal, div_zero, hi, lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b illegal=%b dz=%b hi=%h lo=%h, want all 0", busy, done, illegal, div_zero, hi, lo);
        end
        @(negedge clk) reset_n = 1'b1;
        hl_model = '0;
    endtask

    task automatic run_check(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic dz;
        logic [63:0] e;
        e = model(f, a, b);
        issue(f, a, b);
        wait_done(lat, dz);
        n_chk++;
        if (lat !== 32) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, want 32", name, lat);
        end
        n_chk++;
        if ({hi, lo} !== e) begin
            n_fail++;
            $display("FAIL %s_result f=%b a=%h b=%h: got hi=%h lo=%h, want hi=%h lo=%h", name, f, a, b, hi, lo, e[63:32], e[31:0]);
        end
        n_chk++;
        if (dz !== (f[1] && b == 0)) begin
            n_fail++;
            $display("FAIL %s_div_zero a=%h b=%h: got %b, want %b", name, a, b, dz, f[1] && b == 0);
        end
        hl_model = e;
        @(posedge clk); #1;
        n_chk++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_done_pulse: got busy=%b done=%b, want 0 0", name, busy, done);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        run_check("mult_fixed", F_MULT, 32'hFFFFFFFD, 32'd7);
        for (int i = 0; i < 12; i++) begin
            a = (i % 4 == 1) ? 32'h80000000 : $urandom;
            b = (i % 4 == 2) ? 32'hFFFFFFFF : $urandom;
            run_check("mul_rand", $urandom_range(0, 1) ? F_MULTU : F_MULT, a, b);
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [31:0] a, b;
        run_check("divu_fixed", F_DIVU, 32'd100, 32'd7);
        run_check("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2);
        run_check("div_min", F_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_check("div_zero", F_DIV, 32'd5, 32'd0);
        run_check("divu_zero", F_DIVU, 32'h89ABCDEF, 32'd0);
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : (i % 3 == 1) ? -32'($urandom_range(1, 9)) : $urandom;
            run_check("div_rand", $urandom_range(0, 1) ? F_DIVU : F_DIV, a, b);
        end
    endtask
`else
    task automatic test_div_disabled();
        issue(F_DIVU, 32'd100, 32'd7);
        n_chk++;
        if ({illegal, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL divu_disabled: got illegal=%b busy=%b, want 1 0", illegal, busy);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({busy, hi, lo} !== {1'b0, hl_model}) begin
            n_fail++;
            $display("FAIL divu_disabled_state: got busy=%b hi=%h lo=%h, want 0 %h", busy, hi, lo, hl_model);
        end
    endtask
`endif

    task automatic test_mt();
        @(negedge clk);
        start = 1'b1; Funct = F_MTHI; A = 32'h1234;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b, want 0", busy); end
        @(negedge clk);
        Funct = F_MTLO; A = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        hl_model = {32'h1234, 32'h5678};
        n_chk++;
        if ({busy, done, hi, lo} !== {2'b00, hl_model}) begin
            n_fail++;
            $display("FAIL mthi_mtlo: got busy=%b done=%b hi=%h lo=%h, want 0 0 %h", busy, done, hi, lo, hl_model);
        end
        issue(6'b111111, $urandom, $urandom);
        n_chk++;
        if ({illegal, busy, hi, lo} !== {2'b10, hl_model}) begin
            n_fail++;
            $display("FAIL illegal_pulse: got illegal=%b busy=%b hi=%h lo=%h, want 1 0 %h", illegal, busy, hi, lo, hl_model);
        end
        @(posedge clk); #1;
        n_chk++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_width: got %b, want 0", illegal); end
    endtask

    task automatic test_flush_idle();
        logic [5:0] fs [3];
        fs[0] = F_MTHI; fs[1] = F_MULT; fs[2] = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; flush = 1'b1; Funct = fs[i]; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            n_chk++;
            if ({busy, illegal, hi, lo} !== {2'b00, hl_model}) begin
                n_fail++;
                $display("FAIL flush_idle f=%b: got busy=%b illegal=%b hi=%h lo=%h, want 0 0 %h", fs[i], busy, illegal, hi, lo, hl_model);
            end
        end
    endtask

    task automatic test_flush_busy();
        int seen = 0;
        issue(F_MULTU, $urandom, $urandom);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_idle: got busy=%b, want 0", busy); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_chk++;
        if (seen !== 0 || {hi, lo} !== hl_model) begin
            n_fail++;
            $display("FAIL flush_busy_result: got done_cycles=%0d hi=%h lo=%h, want 0 %h", seen, hi, lo, hl_model);
        end
    endtask

    task automatic test_flush_done();
        int lat;
        logic dz;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        hl_model = model(F_MULT, a, b);
        issue(F_MULT, a, b);
        wait_done(lat, dz);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_chk++;
        if ({lat == 32, busy, done, hi, lo} !== {3'b100, hl_model}) begin
            n_fail++;
            $display("FAIL flush_done: got lat=%0d busy=%b done=%b hi=%h lo=%h, want 32 0 0 %h", lat, busy, done, hi, lo, hl_model);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ill = 0;
        logic dz;
        logic [31:0] a, b;
        logic [5:0] fs [3];
        fs[0] = 6'b111111; fs[1] = F_MTHI; fs[2] = F_MULTU;
        a = $urandom; b = $urandom;
        hl_model = model(F_MULT, a, b);
        issue(F_MULT, a, b);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; Funct = fs[i]; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            if (illegal) ill++;
        end
        start = 1'b0;
        wait_done(lat, dz);
        n_chk++;
        if (ill !== 0 || {done, hi, lo} !== {1'b1, hl_model}) begin
            n_fail++;
            $display("FAIL start_while_busy: got illegal_cycles=%0d done=%b hi=%h lo=%h, want 0 1 %h", ill, done, hi, lo, hl_model);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_while_busy_idle: got busy=%b, want 0", busy); end
    endtask

    task automatic test_reset_mid();
        issue(F_MULT, $urandom, $urandom);
        repeat (5) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({busy, done, illegal, div_zero, hi, lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b illegal=%b dz=%b hi=%h lo=%h, want all 0", busy, done, illegal, div_zero, hi, lo);
        end
        @(negedge clk) reset_n = 1'b1;
        hl_model = '0;
        run_check("after_reset", F_MULTU, $urandom, $urandom);
    endtask

    initial begin
        test_reset();
        test_mul();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_mt();
        test_flush_idle();
        test_flush_busy();
        test_flush_done();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
